// File: rtl/coin_dispenser.sv
// Greedy change dispenser: ejects quarters, dimes, nickels, pennies over a
// four-phase req/ack handshake. Optional ack watchdog: COIN_DISPENSE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start, ready=1
// SELECT | pick largest coin not exceeding remaining
// REQ_HI | coin_req=1, waiting for coin_ack=1
// REQ_LO | coin_req=0, waiting for coin_ack=0
// DONE   | one-cycle done pulse
// FAULT  | ack timeout, held until clr
module coin_dispenser #(
    parameter int AMOUNT_W    = 12,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    output logic                ready,
    output logic [1:0]          coin_sel,
    output logic                coin_req,
    input  logic                coin_ack,
    output logic                done,
    output logic                fault,
    output logic [7:0]          coins_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] REQ_HI = 3'd2;
    localparam logic [2:0] REQ_LO = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;

    logic [2:0]          r_state;
    logic [AMOUNT_W-1:0] r_remaining;
    logic [1:0]          r_coin_sel;
    logic [7:0]          r_coins_out;
    logic [1:0]          w_greedy_sel;
    logic [AMOUNT_W-1:0] w_coin_val;
    logic                w_timeout;

    always_comb begin
        w_greedy_sel = 2'd3;
        if (r_remaining >= AMOUNT_W'(25))
            w_greedy_sel = 2'd0;
        else if (r_remaining >= AMOUNT_W'(10))
            w_greedy_sel = 2'd1;
        else if (r_remaining >= AMOUNT_W'(5))
            w_greedy_sel = 2'd2;
    end

    always_comb begin
        w_coin_val = AMOUNT_W'(1);
        case (r_coin_sel)
            2'd0:    w_coin_val = AMOUNT_W'(25);
            2'd1:    w_coin_val = AMOUNT_W'(10);
            2'd2:    w_coin_val = AMOUNT_W'(5);
            default: w_coin_val = AMOUNT_W'(1);
        endcase
    end

`ifdef COIN_DISPENSE_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] r_ack_cnt;

    // Down-counter reloaded in SELECT, so every REQ_HI entry starts a fresh window.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_ack_cnt <= '0;
        else if (r_state == SELECT)
            r_ack_cnt <= CNT_W'(ACK_TIMEOUT - 1);
        else if (r_state == REQ_HI && r_ack_cnt != '0)
            r_ack_cnt <= r_ack_cnt - 1'b1;
    end

    assign w_timeout = (r_ack_cnt == '0);
    assign fault     = (r_state == FAULT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (ACK_TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_coin_sel  <= 2'd0;
            r_coins_out <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= amount;
                        r_coins_out <= 8'd0;
                        r_state     <= (amount == '0) ? DONE : SELECT;
                    end
                end
                SELECT: begin
                    r_coin_sel <= w_greedy_sel;
                    r_state    <= REQ_HI;
                end
                REQ_HI: begin
                    if (coin_ack) begin
                        // Greedy choice guarantees w_coin_val <= r_remaining.
                        r_remaining <= r_remaining - w_coin_val;
                        if (r_coins_out != 8'hFF)
                            r_coins_out <= r_coins_out + 8'd1;
                        r_state <= REQ_LO;
                    end else if (w_timeout) begin
                        r_state <= FAULT;
                    end
                end
                REQ_LO: begin
                    if (!coin_ack)
                        r_state <= (r_remaining == '0) ? DONE : SELECT;
                end
                DONE:    r_state <= IDLE;
                FAULT:   r_state <= FAULT;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign coin_req  = (r_state == REQ_HI);
    assign done      = (r_state == DONE);
    assign coin_sel  = r_coin_sel;
    assign coins_out = r_coins_out;

endmodule

// File: tb/tb_coin_dispenser.sv
// Scoreboard bench for coin_dispenser: expected coins and final counts are
// queued at stimulus time and popped by a monitor on coin_req rise and done.
module tb_coin_dispenser;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [11:0] amount = '0;
    logic        ready;
    logic [1:0]  coin_sel;
    logic        coin_req;
    logic        ack_resp = 1'b0;
    logic        ack_force = 1'b0;
    logic        coin_ack;
    logic        done;
    logic        fault;
    logic [7:0]  coins_out;
    logic        ack_en = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int q_coin[$];
    int q_done[$];

    assign coin_ack = ack_resp | ack_force;

    coin_dispenser #(.AMOUNT_W(12), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .clr(clr), .start(start), .amount(amount),
        .ready(ready), .coin_sel(coin_sel), .coin_req(coin_req),
        .coin_ack(coin_ack), .done(done), .fault(fault), .coins_out(coins_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Dispenser model: acks a request one cycle after seeing it.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_en && coin_req) begin
                @(posedge clk); #1;
                ack_resp = 1'b1;
                for (int k = 0; k < 50 && coin_req; k++) begin
                    @(posedge clk); #1;
                end
                ack_resp = 1'b0;
            end
        end
    end

    // Monitor.
    logic       prev_req = 1'b0;
    logic       prev_done = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    always @(negedge clk) begin
        if (!clr) begin
            if (coin_req && !prev_req) begin
                if (q_coin.size() == 0) check("unexpected_coin_req", 1, 0);
                else check("coin_sel", int'(coin_sel), q_coin.pop_front());
            end
            if (coin_req && prev_req) check("coin_sel_stable", int'(coin_sel), int'(prev_sel));
            if (done) begin
                check("done_one_cycle", int'(prev_done), 0);
                if (q_done.size() == 0) check("unexpected_done", 1, 0);
                else check("coins_out_at_done", int'(coins_out), q_done.pop_front());
            end
        end
        prev_req  = coin_req;
        prev_done = done;
        prev_sel  = coin_sel;
    end

    task automatic do_start(input int amt);
        @(negedge clk);
        start  = 1'b1;
        amount = 12'(amt);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && !ready; i++) @(negedge clk);
        check("back_to_idle", int'(ready), 1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 200 && !coin_req; i++) @(negedge clk);
        check("req_seen", int'(coin_req), 1);
    endtask

    initial begin
        int cnt;
        // Reset values while clr held
        #2;
        check("rst_ready", int'(ready), 1);
        check("rst_coin_req", int'(coin_req), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_coins_out", int'(coins_out), 0);
        check("rst_coin_sel", int'(coin_sel), 0);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        // 41 = 25 + 10 + 5 + 1, with latency checks
        q_coin.push_back(0); q_coin.push_back(1); q_coin.push_back(2); q_coin.push_back(3);
        q_done.push_back(4);
        do_start(41);
        check("lat_ready_low", int'(ready), 0);
        check("lat_req_not_yet", int'(coin_req), 0);
        @(negedge clk);
        check("lat_req_high", int'(coin_req), 1);
        wait_idle();
        repeat (5) @(negedge clk);

        // amount = 0
        q_done.push_back(0);
        do_start(0);
        check("zero_done_next_cycle", int'(done), 1);
        check("zero_coins_out", int'(coins_out), 0);
        wait_idle();

        // 4095 = 163 quarters + 2 dimes
        for (int i = 0; i < 163; i++) q_coin.push_back(0);
        q_coin.push_back(1); q_coin.push_back(1);
        q_done.push_back(165);
        do_start(4095);
        wait_idle();

        // start during REQ_HI ignored: 20 = two dimes
        q_coin.push_back(1); q_coin.push_back(1);
        q_done.push_back(2);
        do_start(20);
        wait_req();
        start  = 1'b1;
        amount = 12'd7;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();
        check("ignored_start_coins", int'(coins_out), 2);

        // clr in REQ_HI
        ack_en = 1'b0;
        q_coin.push_back(0);
        do_start(30);
        wait_req();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_req_drop", int'(coin_req), 0);
        check("clr_ready", int'(ready), 1);
        check("clr_coins_out", int'(coins_out), 0);
        check("clr_done", int'(done), 0);
        #1 clr = 1'b0;
        repeat (4) @(negedge clk);
        check("after_clr_ready", int'(ready), 1);
        ack_en = 1'b1;
        q_coin.push_back(2);
        q_done.push_back(1);
        do_start(5);
        wait_idle();

        // ack timeout behaviour
        ack_en = 1'b0;
        q_coin.push_back(3);
        do_start(1);
        wait_req();
        cnt = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (coin_req) cnt++;
        end
`ifdef COIN_DISPENSE_TIMEOUT_EN
        check("timeout_cycles_in_req_hi", cnt, 255);
        check("timeout_fault", int'(fault), 1);
        check("timeout_req_low", int'(coin_req), 0);
`else
        check("no_timeout_req_held", int'(coin_req), 1);
        check("no_timeout_fault", int'(fault), 0);
`endif
        check("timeout_ready_low", int'(ready), 0);
        check("timeout_coins_out", int'(coins_out), 0);
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_fault", int'(fault), 0);
        check("clr_ready2", int'(ready), 1);
        #1 clr = 1'b0;

        // coin_ack outside REQ_HI has no effect
        @(negedge clk);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        check("stray_ack_coins_out", int'(coins_out), 0);
        check("stray_ack_ready", int'(ready), 1);
        check("stray_ack_req", int'(coin_req), 0);

        repeat (5) @(negedge clk);
        check("coin_queue_drained", q_coin.size(), 0);
        check("done_queue_drained", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
